e203_ifu_flush_fetch_ctrl: RTL

- Consumer of the commit stage's pipeline-flush interface and WFI halt request; owns the architectural fetch PC.
- Computes the redirect PC (op1+op2) on flush, then issues sequential fetch requests to the instruction bus with bounded outstanding transactions.
- Discards responses belonging to pre-flush requests; pairs each surviving response with its PC and forwards it to the decode-side output.
- Handles WFI halt: drains outstanding fetches, then acknowledges.

---
 rtl/e203_ifu_flush_fetch_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/e203_ifu_flush_fetch_ctrl.sv
// IFU fetch controller: owns the fetch PC, issues sequential fetches, drops stale
// responses after a flush, and drains for WFI. Define E203_FLUSH_DIRECT_PC_EN to redirect from pipe_flush_pc.
module e203_ifu_flush_fetch_ctrl #(
    parameter int              PC_SIZE  = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC = 32'h0000_1000,
    parameter int              OUTS_MAX = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_flush_req,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
    input  logic [PC_SIZE-1:0] pipe_flush_pc,
    output logic               pipe_flush_ack,
    input  logic               wfi_halt_ifu_req,
    output logic               wfi_halt_ifu_ack,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    output logic [PC_SIZE-1:0] ifu_req_pc,
    input  logic               ifu_rsp_valid,
    output logic               ifu_rsp_ready,
    input  logic [31:0]        ifu_rsp_instr,
    output logic               ifu_o_valid,
    input  logic               ifu_o_ready,
    output logic [PC_SIZE-1:0] ifu_o_pc,
    output logic [31:0]        ifu_o_instr
);

    // Handshake rule on every channel: a transfer happens in a cycle where valid
    // and ready are both high at the rising edge; valid, once raised, is held until then.

    localparam int CW = $clog2(OUTS_MAX + 1);
    localparam int AW = (OUTS_MAX > 1) ? $clog2(OUTS_MAX) : 1;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT_DRAIN = 2'd1,
        HALTED     = 2'd2
    } state_t;

    state_t             state_r;
    logic               ack_r;
    logic [PC_SIZE-1:0] pc_r;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      drop_cnt_r;
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [PC_SIZE-1:0] fifo_q [OUTS_MAX];

    logic               dropping;
    logic               req_hs;
    logic               rsp_hs;
    logic [PC_SIZE-1:0] redirect_pc;

`ifdef E203_FLUSH_DIRECT_PC_EN
    logic unused_ops;
    assign unused_ops  = ^{pipe_flush_add_op1, pipe_flush_add_op2};
    assign redirect_pc = pipe_flush_pc;
`else
    logic unused_flush_pc;
    assign unused_flush_pc = ^pipe_flush_pc;
    assign redirect_pc     = pipe_flush_add_op1 + pipe_flush_add_op2;
`endif

    assign dropping = (drop_cnt_r != '0);

    // Every output is forced low while reset is asserted.
    assign pipe_flush_ack   = ~rst & pipe_flush_req;
    assign wfi_halt_ifu_ack = ~rst & ack_r;
    assign ifu_req_valid    = ~rst & (state_r == RUN) & ~pipe_flush_req
                              & (cnt_r < CW'(OUTS_MAX));
    assign ifu_req_pc       = rst ? '0 : pc_r;

    // A live response waiting during a flush cycle is held off; it becomes stale
    // and is counted into drop_cnt by the flush itself.
    assign ifu_rsp_ready = ~rst & (dropping | (~pipe_flush_req & ifu_o_ready));
    assign ifu_o_valid   = ~rst & ~dropping & ~pipe_flush_req & ifu_rsp_valid;
    assign ifu_o_pc      = rst ? '0 : fifo_q[rd_ptr_r];
    assign ifu_o_instr   = rst ? '0 : ifu_rsp_instr;

    assign req_hs = ifu_req_valid & ifu_req_ready;
    assign rsp_hs = ifu_rsp_valid & ifu_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            ack_r      <= 1'b0;
            pc_r       <= RESET_PC;
            cnt_r      <= '0;
            drop_cnt_r <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            for (int i = 0; i < OUTS_MAX; i++) fifo_q[i] <= '0;
        end else begin
            unique case (state_r)
                RUN: begin
                    ack_r <= 1'b0;
                    if (wfi_halt_ifu_req) state_r <= HALT_DRAIN;
                end
                HALT_DRAIN: begin
                    if (!wfi_halt_ifu_req) begin
                        state_r <= RUN;
                    end else if (cnt_r == '0) begin
                        state_r <= HALTED;
                        ack_r   <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!wfi_halt_ifu_req) begin
                        state_r <= RUN;
                        ack_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= RUN;
                    ack_r   <= 1'b0;
                end
            endcase

            if (pipe_flush_ack) pc_r <= redirect_pc;
            else if (req_hs)    pc_r <= pc_r + PC_SIZE'(4);

            if (req_hs && !rsp_hs)      cnt_r <= cnt_r + CW'(1);
            else if (!req_hs && rsp_hs) cnt_r <= cnt_r - CW'(1);

            // Everything still outstanding after this cycle predates the redirect.
            if (pipe_flush_ack)         drop_cnt_r <= cnt_r - CW'(rsp_hs);
            else if (rsp_hs && dropping) drop_cnt_r <= drop_cnt_r - CW'(1);

            if (req_hs) begin
                fifo_q[wr_ptr_r] <= pc_r;
                wr_ptr_r <= (wr_ptr_r == AW'(OUTS_MAX - 1)) ? '0 : wr_ptr_r + AW'(1);
            end
            if (rsp_hs) begin
                rd_ptr_r <= (rd_ptr_r == AW'(OUTS_MAX - 1)) ? '0 : rd_ptr_r + AW'(1);
            end
        end
    end

    rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) ifu_rsp_valid |-> (cnt_r != '0)
    );

endmodule
